// File: rtl/scalar_mult_sequencer_pkg.sv
// Shared constants and state encoding for the scalar-multiplication sequencer.
package scalar_mult_sequencer_pkg;

  // ALU opcodes driven on out_alu_state.
  localparam logic [1:0] OP_PRECAL = 2'd0;
  localparam logic [1:0] OP_DOUBLE = 2'd1;
  localparam logic [1:0] OP_DIVINV = 2'd2;
  localparam logic [1:0] OP_DIVMUL = 2'd3;

  // Field prime q = 2^255 - 19 and the inversion exponent q - 2 = 2^255 - 21.
  localparam logic [254:0] Q         = {{250{1'b1}}, 5'b01101};
  localparam logic [254:0] Q_MINUS_2 = Q - 255'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DBL,
    S_RINIT,
    S_INV,
    S_MUL,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/scalar_mult_sequencer_bit_walker.sv
// MSB-first bit walker: an 8-bit index down-counter plus the registered
// keep/consecutive flags for the op currently in flight.
module scalar_mult_sequencer_bit_walker #(
  parameter int unsigned Width = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [7:0]       load_idx,
  input  logic [Width-1:0] bits,
  output logic [7:0]       idx,
  output logic             keep,
  output logic             cons
);

  logic [7:0] idx_q, idx_d, idx_m1;
  logic       keep_q, keep_d;
  logic       cons_q, cons_d;

  // Load the top index of a new phase, or step down one bit on each ready.
  always_comb begin
    idx_m1 = idx_q - 8'd1;
    idx_d  = idx_q;
    keep_d = keep_q;
    cons_d = cons_q;
    if (load) begin
      idx_d  = load_idx;
      keep_d = (load_idx != 8'd0);
      cons_d = bits[load_idx];
    end else if (step && (idx_q != 8'd0)) begin
      idx_d  = idx_m1;
      keep_d = (idx_m1 != 8'd0);
      cons_d = bits[idx_m1];
    end
  end

  // Index and flag registers; flags only move on load/step so they hold per op.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= 8'd0;
      keep_q <= 1'b0;
      cons_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      keep_q <= keep_d;
      cons_q <= cons_d;
    end
  end

  assign idx  = idx_q;
  assign keep = keep_q;
  assign cons = cons_q;

endmodule

// File: rtl/scalar_mult_sequencer.sv
// Turns one scalar-multiplication request into the ALU op stream:
// PRE-CAL, DOUBLE[+ADD] per scalar bit, DIV-INV per exponent bit, DIV-MUL.
module scalar_mult_sequencer
  import scalar_mult_sequencer_pkg::*;
#(
  parameter int unsigned SCALAR_W = 255,
  parameter int unsigned EXP_W    = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_start,
  input  logic [SCALAR_W-1:0] in_scalar,
  input  logic                in_alu_ready,
  output logic                out_alu_valid,
  output logic [1:0]          out_alu_state,
  output logic                out_alu_keep_flag,
  output logic                out_alu_consecutive_flag,
  output logic                out_r_init,
  output logic                out_busy,
  output logic                out_done
);

  localparam int unsigned WalkW = (SCALAR_W > EXP_W) ? SCALAR_W : EXP_W;

  seq_state_e          state_q, state_d;
  logic [SCALAR_W-1:0] k_q, k_d;
  logic                issue_q, issue_d;

  logic             wk_load, wk_step;
  logic [7:0]       wk_load_idx, wk_idx;
  logic             wk_keep, wk_cons;
  logic [WalkW-1:0] walk_bits;

  // Bit source for the walker: exponent from r_init onward, latched scalar before.
  always_comb begin
    walk_bits = '0;
    if ((state_q == S_RINIT) || (state_q == S_INV)) begin
      walk_bits[EXP_W-1:0] = Q_MINUS_2[EXP_W-1:0];
    end else begin
      walk_bits[SCALAR_W-1:0] = k_q;
    end
  end

  scalar_mult_sequencer_bit_walker #(
    .Width (WalkW)
  ) u_bit_walker (
    .clk      (clk),
    .rst      (rst),
    .load     (wk_load),
    .step     (wk_step),
    .load_idx (wk_load_idx),
    .bits     (walk_bits),
    .idx      (wk_idx),
    .keep     (wk_keep),
    .cons     (wk_cons)
  );

  // Next-state logic; issue_d marks the first cycle of the next op phase.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    issue_d     = 1'b0;
    wk_load     = 1'b0;
    wk_step     = 1'b0;
    wk_load_idx = 8'd0;
    unique case (state_q)
      S_IDLE: begin
        if (in_start) begin
          k_d     = in_scalar;
          state_d = S_PRE;
          issue_d = 1'b1;
        end
      end
      S_PRE: begin
        if (in_alu_ready) begin
          state_d     = S_DBL;
          issue_d     = 1'b1;
          wk_load     = 1'b1;
          wk_load_idx = 8'(SCALAR_W - 1);
        end
      end
      S_DBL: begin
        if (in_alu_ready) begin
          if (wk_idx == 8'd0) state_d = S_RINIT;
          else                wk_step = 1'b1;
        end
      end
      S_RINIT: begin
        state_d     = S_INV;
        issue_d     = 1'b1;
        wk_load     = 1'b1;
        wk_load_idx = 8'(EXP_W - 1);
      end
      S_INV: begin
        if (in_alu_ready) begin
          if (wk_idx == 8'd0) begin
            state_d = S_MUL;
            issue_d = 1'b1;
          end else begin
            wk_step = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (in_alu_ready) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched scalar and issue-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      issue_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      issue_q <= issue_d;
    end
  end

  // Outputs decoded from the current state; flags only visible in walking phases.
  always_comb begin
    out_alu_valid            = issue_q;
    out_alu_state            = OP_PRECAL;
    out_alu_keep_flag        = 1'b0;
    out_alu_consecutive_flag = 1'b0;
    out_r_init               = (state_q == S_RINIT);
    out_busy                 = (state_q != S_IDLE);
    out_done                 = (state_q == S_DONE);
    unique case (state_q)
      S_DBL: begin
        out_alu_state            = OP_DOUBLE;
        out_alu_keep_flag        = wk_keep;
        out_alu_consecutive_flag = wk_cons;
      end
      S_INV: begin
        out_alu_state            = OP_DIVINV;
        out_alu_keep_flag        = wk_keep;
        out_alu_consecutive_flag = wk_cons;
      end
      S_MUL:   out_alu_state = OP_DIVMUL;
      default: out_alu_state = OP_PRECAL;
    endcase
  end

endmodule

// File: tb/tb_scalar_mult_sequencer.sv
// Self-checking bench: cycle-accurate ALU model plus a table of scalar runs
// and hand-written reset / spurious-input sequences.
module tb_scalar_mult_sequencer;

  logic         clk;
  logic         rst;
  logic         in_start;
  logic [254:0] in_scalar;
  logic         in_alu_ready;
  logic         out_alu_valid;
  logic [1:0]   out_alu_state;
  logic         out_alu_keep_flag;
  logic         out_alu_consecutive_flag;
  logic         out_r_init;
  logic         out_busy;
  logic         out_done;

  scalar_mult_sequencer #(
    .SCALAR_W (255),
    .EXP_W    (255)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .in_start                 (in_start),
    .in_scalar                (in_scalar),
    .in_alu_ready             (in_alu_ready),
    .out_alu_valid            (out_alu_valid),
    .out_alu_state            (out_alu_state),
    .out_alu_keep_flag        (out_alu_keep_flag),
    .out_alu_consecutive_flag (out_alu_consecutive_flag),
    .out_r_init               (out_r_init),
    .out_busy                 (out_busy),
    .out_done                 (out_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // ALU model state
  logic active, chain_pend, op_keep, op_cons;
  int   cnt;
  // Recorded op stream
  int           nvalid, viol;
  logic [7:0]   vs;
  int           dbl_n, dbl_keep0, inv_n, inv_keep0;
  logic         dbl_last_keep, inv_last_keep;
  logic [254:0] dbl_cons_v, inv_cons_v;

  typedef struct {
    logic [254:0] k;
    int           mode;     // 0 plain, 1 start pulse mid-DBL, 2 spurious ready in r_init
    int           exp_done; // done cycle relative to start acceptance
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int lat(input logic [1:0] st, input logic c);
    if (st == 2'd1) return c ? 19 : 10;
    return 4;
  endfunction

  task automatic reset_model();
    active = 0; chain_pend = 0; op_keep = 0; op_cons = 0; cnt = 0;
    nvalid = 0; viol = 0; vs = 8'h0;
    dbl_n = 0; dbl_keep0 = 0; inv_n = 0; inv_keep0 = 0;
    dbl_last_keep = 1'b1; inv_last_keep = 1'b1;
    dbl_cons_v = '0; inv_cons_v = '0;
  endtask

  task automatic record(input logic [1:0] st, input logic c, input logic kp);
    if (st == 2'd1) begin
      if (dbl_n < 255) dbl_cons_v[254-dbl_n] = c;
      dbl_n++;
      if (!kp) dbl_keep0++;
      dbl_last_keep = kp;
    end else if (st == 2'd2) begin
      if (inv_n < 255) inv_cons_v[254-inv_n] = c;
      inv_n++;
      if (!kp) inv_keep0++;
      inv_last_keep = kp;
    end
  endtask

  // One cycle of the ALU model: observe DUT outputs, drive ready for this cycle.
  task automatic alu_cycle();
    logic rdy;
    rdy = 1'b0;
    if (out_alu_valid && (active || chain_pend)) viol++;
    if (active) begin
      if (out_alu_keep_flag !== op_keep || out_alu_consecutive_flag !== op_cons) viol++;
      cnt--;
      if (cnt == 0) begin
        rdy        = 1'b1;
        active     = 0;
        chain_pend = op_keep;
      end
    end else if (chain_pend) begin
      chain_pend = 0;
      active     = 1;
      op_keep    = out_alu_keep_flag;
      op_cons    = out_alu_consecutive_flag;
      cnt        = lat(out_alu_state, op_cons) - 1;
      record(out_alu_state, op_cons, op_keep);
    end
    if (out_alu_valid) begin
      nvalid++;
      vs      = {vs[5:0], out_alu_state};
      active  = 1;
      op_keep = out_alu_keep_flag;
      op_cons = out_alu_consecutive_flag;
      cnt     = lat(out_alu_state, op_cons);
      record(out_alu_state, op_cons, op_keep);
    end
    in_alu_ready = rdy;
  endtask

  function automatic logic [255:0] outs();
    return 256'({out_alu_valid, out_alu_state, out_alu_keep_flag, out_alu_consecutive_flag,
                 out_r_init, out_busy, out_done});
  endfunction

  task automatic run_vec(input int vi, input logic [254:0] k, input int mode,
                         input int exp_done, input logic [254:0] qm2);
    int t, done_at, ndone, nbusy, nrinit;
    string p;
    p = $sformatf("v%0d", vi);
    reset_model();
    done_at = -1; ndone = 0; nbusy = 0; nrinit = 0;
    in_scalar = k;
    in_start  = 1'b1;
    t = cyc;
    for (int i = 0; i < 8000; i++) begin
      tick();
      if (cyc == t + 1) begin
        in_start  = 1'b0;
        in_scalar = ~k;
      end
      alu_cycle();
      if (out_done) begin
        ndone++;
        done_at = cyc;
      end
      if (out_busy) nbusy++;
      if (out_r_init) begin
        nrinit++;
        if (mode == 2) in_alu_ready = 1'b1;
      end
      if (mode == 1 && cyc == t + 100) in_start = 1'b1;
      if (mode == 1 && cyc == t + 101) in_start = 1'b0;
      if (ndone > 0 && cyc >= done_at + 20) break;
    end
    check({p, "_done_cycle"}, 256'(done_at - t), 256'(exp_done));
    check({p, "_done_pulses"}, 256'(ndone), 256'd1);
    check({p, "_busy_cycles"}, 256'(nbusy), 256'(exp_done));
    check({p, "_valid_pulses"}, 256'(nvalid), 256'd4);
    check({p, "_valid_states"}, 256'(vs), 256'h1B);
    check({p, "_dbl_ops"}, 256'(dbl_n), 256'd255);
    check({p, "_dbl_cons"}, 256'(dbl_cons_v), 256'(k));
    check({p, "_dbl_keep0"}, 256'({dbl_keep0[7:0], dbl_last_keep}), 256'({8'd1, 1'b0}));
    check({p, "_inv_ops"}, 256'(inv_n), 256'd255);
    check({p, "_inv_cons"}, 256'(inv_cons_v), 256'(qm2));
    check({p, "_inv_keep0"}, 256'({inv_keep0[7:0], inv_last_keep}), 256'({8'd1, 1'b0}));
    check({p, "_r_init"}, 256'(nrinit), 256'd1);
    check({p, "_hold_viol"}, 256'(viol), 256'd0);
  endtask

  initial begin
    logic [255:0] qm2_full;
    logic [254:0] qm2;
    logic [254:0] ones;
    int           t, ndone;
    qm2_full = (256'd1 << 255) - 256'd21;
    qm2      = qm2_full[254:0];
    ones     = '1;

    vecs[0] = '{k: 255'd0,          mode: 0, exp_done: 3584};
    vecs[1] = '{k: 255'd1,          mode: 0, exp_done: 3593};
    vecs[2] = '{k: ones,            mode: 0, exp_done: 5879};
    vecs[3] = '{k: 255'd1 << 254,   mode: 0, exp_done: 3593};
    vecs[4] = '{k: 255'hA5,         mode: 0, exp_done: 3620};
    vecs[5] = '{k: 255'h3,          mode: 1, exp_done: 3602};
    vecs[6] = '{k: 255'h5,          mode: 2, exp_done: 3602};

    rst          = 1'b1;
    in_start     = 1'b0;
    in_scalar    = '0;
    in_alu_ready = 1'b0;
    tick();
    tick();
    check("reset_outputs", outs(), 256'd0);
    rst = 1'b0;
    tick();
    tick();
    check("idle_outputs", outs(), 256'd0);

    for (int i = 0; i < 7; i++) begin
      run_vec(i, vecs[i].k, vecs[i].mode, vecs[i].exp_done, qm2);
    end

    // Reset in the middle of the DIV-INV phase.
    reset_model();
    in_scalar = 255'h5;
    in_start  = 1'b1;
    t = cyc;
    for (int i = 0; i < 6000; i++) begin
      tick();
      if (cyc == t + 1) in_start = 1'b0;
      alu_cycle();
      if (inv_n >= 10) break;
    end
    check("rst_reached_inv", 256'(inv_n >= 10), 256'd1);
    rst = 1'b1;
    tick();
    rst          = 1'b0;
    in_alu_ready = 1'b0;
    check("rst_mid_inv_outputs", outs(), 256'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_done || out_busy || out_alu_valid) ndone++;
    end
    check("rst_no_activity", 256'(ndone), 256'd0);
    run_vec(7, 255'd0, 0, 3584, qm2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scalar_mult_sequencer.md
# scalar_mult_sequencer

Command-side controller for the point-arithmetic ALU. It turns one scalar-multiplication request into the ALU operation stream:
- PRE-CAL once;
- one DOUBLE per scalar bit (MSB first), with ADD chained when the bit is 1;
- one DIV-INV per exponent bit of q−2 (square, then multiply by Z or 1);
- a final DIV-MUL.

It drives the ALU's valid/state/keep/consecutive inputs, consumes the ALU's ready pulse, and reports busy/done to the top-level controller.

## Interface
- SCALAR_W, 255, number of scalar bits processed, MSB first.
- EXP_W, 255, number of exponent bits of q−2 processed, MSB first.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- in_start  in  1  start request; sampled only in S_IDLE.
- in_scalar  in  SCALAR_W  scalar k; latched when in_start is accepted.
- in_alu_ready  in  1  ALU last-cycle pulse (one pulse per DOUBLE[+ADD], PRE-CAL, DIV-INV or DIV-MUL op).
- out_alu_valid  out  1  one-cycle issue pulse to the idle ALU.
- out_alu_state  out  2  opcode: 0 PRE-CAL, 1 DOUBLE, 2 DIV-INV, 3 DIV-MUL.
- out_alu_keep_flag  out  1  the next op chains directly, with no valid pulse.
- out_alu_consecutive_flag  out  1  DOUBLE: chain ADD. DIV-INV: multiply by Z_reg, else by 1.
- out_r_init  out  1  one-cycle pulse: top level loads r = 1 into A2_lut.
- out_busy  out  1  high from the cycle after start acceptance through the done cycle.
- out_done  out  1  one-cycle completion pulse.

## Operation
- States: S_IDLE, S_PRE, S_DBL, S_RINIT, S_INV, S_MUL, S_DONE.
- Bit index idx: 8-bit down-counter, reloaded on entry to S_DBL (SCALAR_W−1) and S_INV (EXP_W−1).
- S_IDLE, in_start=1:
  - latch scalar into k_r;
  - go to S_PRE.
  - in_start is ignored in every other state.
- S_PRE:
  - first cycle: valid=1, state=0, keep=0, cons=0;
  - on ready: go to S_DBL.
- S_DBL:
  - first cycle: valid=1, state=1, cons=k_r[idx], keep=(idx≠0).
  - On each ready with idx≠0: idx−1; cons←k_r[idx−1]; keep←(idx−1≠0). Both are registered on the ready edge, so the chained op sees them from its first cycle.
  - On ready with idx=0: go to S_RINIT.
- S_RINIT: out_r_init=1 for one cycle, then go to S_INV.
- S_INV:
  - same pattern as S_DBL with state=2 and cons=Q_MINUS_2[idx];
  - on the final ready: go to S_MUL.
- S_MUL:
  - first cycle: valid=1, state=3, keep=0, cons=0;
  - on ready: go to S_DONE.
- S_DONE: done=1 for one cycle, then go to S_IDLE.
- Flag hold rule: keep and cons stay constant for the whole op; they change only on a ready edge.
- out_alu_valid is asserted only on the first cycle of S_PRE, S_DBL, S_INV and S_MUL; never mid-chain.
- out_alu_state holds its value for the whole phase.
- A ready pulse arriving in S_IDLE, S_RINIT or S_DONE is ignored.

## Timing
- Reset: state S_IDLE, idx=0, k_r=0. All outputs are 0, including out_alu_state=0.
- Reset mid-operation: back to S_IDLE on the next edge with every output 0. No done pulse is produced.
- ALU op latency, with ready at v+n after valid at v (chained ops: ready+n):
  - PRE-CAL: n=4;
  - DOUBLE: n=10;
  - DOUBLE+ADD: n=19;
  - DIV-INV: n=4;
  - DIV-MUL: n=4.
- Start accepted at t:
  - PRE valid at t+1;
  - DBL valid at t+6;
  - last DBL ready at t+2556+9·popcount(k);
  - r_init one cycle after that, then INV valid one cycle later;
  - last INV ready INV valid + 1020;
  - MUL valid +1;
  - ready +4;
  - done +1.
- k=0 gives done at t+3584.

## Structure
- Shared package holds:
  - opcode constants (OP_PRECAL=0, OP_DOUBLE=1, OP_DIVINV=2, OP_DIVMUL=3);
  - Q and Q_MINUS_2 = 2^255−21 (bits 4 and 2 zero, all other 255 bits one);
  - the sequencer state encoding.
- Natural sub-module: bit_walker (idx down-counter plus flag register), instantiated once and reloaded per phase.

## Test plan
- k=0, cycle-accurate ALU model:
  - 255 DOUBLE ops, all with cons=0;
  - exactly four valid pulses (states 0, 1, 2, 3);
  - done at t+3584.
- k=1:
  - cons=1 only on the last DOUBLE;
  - keep=0 on that op;
  - done at t+3593.
- DIV-INV cons sequence equals Q_MINUS_2 MSB-first: 0 at idx 4 and idx 2, 1 elsewhere; keep=0 only at idx 0.
- in_start pulsed during S_DBL: no effect on k_r or the op stream; exactly one done pulse.
- rst asserted mid-S_INV:
  - all outputs 0 the next cycle;
  - a new start then runs to a normal done.
- Spurious in_alu_ready during S_RINIT: ignored; sequence and cycle counts are unchanged.
